regfile_port_master: RTL and testbench
======================================

Name: regfile_port_master

Overview:
Initiator for the 32-entry register file: the block that drives the file's select, write-enable and data ports on behalf of the multi-cycle datapath. It accepts operand-read requests and writeback requests on valid/ready handshakes. Writebacks are buffered in a small queue and drained one per cycle. Reads are sequenced through an FSM, with bypass from queued, not-yet-written data, so a read never returns stale data.

Parameters:
SIZE, 32, data width of a register
WB_DEPTH, 2, writeback queue entries (power of two, >=2)
ZERO_R0, 1, 1 = writes to r0 are discarded and reads of r0 return 0

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
rd_req_valid  in  1  read request valid
rd_req_ready  out  1  read request accepted when valid&ready
rd_req_a  in  5  operand A register index
rd_req_b  in  5  operand B register index
rd_rsp_valid  out  1  operand response valid
rd_rsp_ready  in  1  consumer accepts response
rd_rsp_a  out  SIZE  operand A value
rd_rsp_b  out  SIZE  operand B value
wb_valid  in  1  writeback request valid
wb_ready  out  1  writeback accepted when valid&ready
wb_dest  in  5  writeback register index
wb_data  in  SIZE  writeback value
rf_a_sel  out  5  to register file A_sel
rf_b_sel  out  5  to register file B_sel
rf_a_data  in  SIZE  from register file A_data (combinational read)
rf_b_data  in  SIZE  from register file B_data (combinational read)
rf_load_en  out  1  to register file Load_En
rf_dest_sel  out  5  to register file Dest_sel
rf_d_data  out  SIZE  to register file D_data

Behaviour:
- Reset values:
  - FSM = IDLE; queue empty (count 0); rd_rsp_valid=0; rd_rsp_a/b=0; rf_a_sel/rf_b_sel=0.
  - rf_load_en=0, rf_dest_sel=0, rf_d_data=0.
  - rd_req_ready=1 and wb_ready=1 in the first cycle after reset.
  - Reset mid-operation discards pending writebacks and any held response.
- Writeback queue: FIFO of {dest,data}, WB_DEPTH entries.
  - wb_ready = !full. No enqueue when full, even if a pop occurs in the same cycle.
  - With ZERO_R0=1, wb_dest==0 is accepted (handshake completes) but not enqueued.
  - Drain: whenever not empty, head drives rf_load_en=1, rf_dest_sel=head.dest, rf_d_data=head.data. The register file writes at the next edge and the head pops at that edge: one write per cycle.
  - When empty: rf_load_en=0, rf_dest_sel=0, rf_d_data=0.
  - Simultaneous push and pop (not full): count unchanged, order preserved.
  - Pointers wrap modulo WB_DEPTH.
- Read FSM, states IDLE, FETCH, RESP:
  - IDLE: rd_req_ready=1. On rd_req_valid, latch rd_req_a/b into rf_a_sel/rf_b_sel (registered); go to FETCH.
  - FETCH: rd_req_ready=0. Compute operand = rf_x_data, overridden by the youngest queue entry whose dest matches the select (bypass). This includes the head being written this same cycle.
    - With ZERO_R0=1, select 0 yields 0 regardless of bypass.
    - Register results into rd_rsp_a/b; go to RESP.
  - RESP: rd_rsp_valid=1. rd_rsp_a/b held stable until rd_rsp_ready; on handshake go to IDLE (rd_rsp_valid=0 next cycle).
- Latency: request accepted at edge N → rd_rsp_valid high in cycle N+2. Sustained throughput: one read per 3 cycles with rd_rsp_ready tied high.
- Ordering:
  - A writeback accepted at an edge strictly before the FETCH cycle is visible to that read.
  - A writeback accepted in the FETCH cycle itself is not visible.
  - Writebacks never stall reads; reads never stall writebacks.
- rd_req_a == rd_req_b is legal; both outputs get the same value.

Decomposition:
- Shared package regfile_pkg: REG_ADDR_W=5, NUM_REGS=32, FSM state enum {IDLE, FETCH, RESP}.
- One sub-module, regfile_wb_queue:
  - FIFO with push/pop, full/empty and head outputs.
  - Two combinational lookup ports (addr in → hit, data out; youngest match wins).
- The FSM and the rf_* port drive stay in regfile_port_master.

Test Plan:
- Reset, then wb r5=0xDEADBEEF with wb_valid only → rf_load_en=1, rf_dest_sel=5, rf_d_data=0xDEADBEEF for exactly 1 cycle, then rf_load_en=0.
- Stub register file holds r3=0x11, r4=0x22; read a=3,b=4, rd_rsp_ready=1 → rd_rsp_valid at cycle N+2 with a=0x11, b=0x22; rd_req_ready low in cycles N+1 and N+2.
- Enqueue r7=0xA then r7=0xB on back-to-back cycles, read a=7 the following cycle → rd_rsp_a=0xB (youngest bypass), not the stale file value.
- Hold wb_valid for 3 consecutive cycles into an empty queue (WB_DEPTH=2) while draining → 3 writes accepted with no wb_ready drop. Second scenario: stall the drain model by checking the full flag → wb_ready=0 when count=2 and no enqueue occurs.
- wb r0=0x55 then read a=0,b=0 → no rf_load_en pulse; rd_rsp_a=rd_rsp_b=0.
- Assert rst while in RESP with rd_rsp_ready=0 and the queue holding 1 entry → next cycle rd_rsp_valid=0, rf_load_en=0, rd_req_ready=1; the pending write is never issued.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file addressing constants and read-sequencer states
package regfile_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        RESP
    } rd_state_e;
endpackage

// File: rtl/regfile_port_master_if.sv
// regfile_port_master_if: operand-read and writeback handshakes between the datapath and the register-file initiator
interface regfile_port_master_if
    import regfile_pkg::*;
#(
    parameter int SIZE = 32
);
    logic                  rd_req_valid;
    logic                  rd_req_ready;
    logic [REG_ADDR_W-1:0] rd_req_a;
    logic [REG_ADDR_W-1:0] rd_req_b;
    logic                  rd_rsp_valid;
    logic                  rd_rsp_ready;
    logic [SIZE-1:0]       rd_rsp_a;
    logic [SIZE-1:0]       rd_rsp_b;
    logic                  wb_valid;
    logic                  wb_ready;
    logic [REG_ADDR_W-1:0] wb_dest;
    logic [SIZE-1:0]       wb_data;

    modport master (
        output rd_req_valid, rd_req_a, rd_req_b, rd_rsp_ready, wb_valid, wb_dest, wb_data,
        input  rd_req_ready, rd_rsp_valid, rd_rsp_a, rd_rsp_b, wb_ready
    );

    modport slave (
        input  rd_req_valid, rd_req_a, rd_req_b, rd_rsp_ready, wb_valid, wb_dest, wb_data,
        output rd_req_ready, rd_rsp_valid, rd_rsp_a, rd_rsp_b, wb_ready
    );
endinterface

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: writeback FIFO with two youngest-match bypass lookup ports
module regfile_wb_queue
    import regfile_pkg::*;
#(
    parameter int SIZE  = 32,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [REG_ADDR_W-1:0] i_dest,
    input  logic [SIZE-1:0]       i_data,
    input  logic                  i_pop,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [REG_ADDR_W-1:0] o_head_dest,
    output logic [SIZE-1:0]       o_head_data,
    input  logic [REG_ADDR_W-1:0] i_la_addr,
    output logic                  o_la_hit,
    output logic [SIZE-1:0]       o_la_data,
    input  logic [REG_ADDR_W-1:0] i_lb_addr,
    output logic                  o_lb_hit,
    output logic [SIZE-1:0]       o_lb_data
);
    localparam int PW = $clog2(DEPTH);

    logic [REG_ADDR_W-1:0] r_dest [DEPTH];
    logic [SIZE-1:0]       r_data [DEPTH];
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW:0]           r_count;
    logic [PW-1:0]         w_idx;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign o_full      = (r_count == (PW+1)'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign w_do_push   = i_push && !o_full;
    assign w_do_pop    = i_pop && !o_empty;
    assign o_head_dest = r_dest[r_rd_ptr];
    assign o_head_data = r_data[r_rd_ptr];

    // storage needs no reset: only entries below r_count are ever looked at
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_dest[r_wr_ptr] <= i_dest;
            r_data[r_wr_ptr] <= i_data;
        end
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + (PW+1)'(w_do_push) - (PW+1)'(w_do_pop);
        end
    end

    // scan oldest to youngest so the youngest matching entry overrides older ones
    always_comb begin
        o_la_hit  = 1'b0;
        o_la_data = '0;
        o_lb_hit  = 1'b0;
        o_lb_data = '0;
        w_idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_rd_ptr + PW'(k);
            if ((PW+1)'(k) < r_count) begin
                if (r_dest[w_idx] == i_la_addr) begin
                    o_la_hit  = 1'b1;
                    o_la_data = r_data[w_idx];
                end
                if (r_dest[w_idx] == i_lb_addr) begin
                    o_lb_hit  = 1'b1;
                    o_lb_data = r_data[w_idx];
                end
            end
        end
    end
endmodule

// File: rtl/regfile_port_master.sv
// regfile_port_master: drives register-file ports for operand reads and queued writebacks
module regfile_port_master
    import regfile_pkg::*;
#(
    parameter int SIZE     = 32,
    parameter int WB_DEPTH = 2,
    parameter int ZERO_R0  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_port_master_if.slave  bus,
    output logic [REG_ADDR_W-1:0] o_rf_a_sel,
    output logic [REG_ADDR_W-1:0] o_rf_b_sel,
    input  logic [SIZE-1:0]       i_rf_a_data,
    input  logic [SIZE-1:0]       i_rf_b_data,
    output logic                  o_rf_load_en,
    output logic [REG_ADDR_W-1:0] o_rf_dest_sel,
    output logic [SIZE-1:0]       o_rf_d_data
);
    rd_state_e             r_state;
    rd_state_e             w_next;
    logic [REG_ADDR_W-1:0] r_a_sel;
    logic [REG_ADDR_W-1:0] r_b_sel;
    logic [SIZE-1:0]       r_rsp_a;
    logic [SIZE-1:0]       r_rsp_b;
    logic [SIZE-1:0]       w_op_a;
    logic [SIZE-1:0]       w_op_b;
    logic [SIZE-1:0]       w_la_data;
    logic [SIZE-1:0]       w_lb_data;
    logic [SIZE-1:0]       w_head_data;
    logic [REG_ADDR_W-1:0] w_head_dest;
    logic                  w_la_hit;
    logic                  w_lb_hit;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;

    // r0 writebacks still complete their handshake but never reach the queue
    assign w_push = bus.wb_valid && !(ZERO_R0 != 0 && bus.wb_dest == '0);

    // the queue drains unconditionally, so pop is always requested
    regfile_wb_queue #(.SIZE(SIZE), .DEPTH(WB_DEPTH)) u_wb_queue (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_dest      (bus.wb_dest),
        .i_data      (bus.wb_data),
        .i_pop       (1'b1),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head_dest (w_head_dest),
        .o_head_data (w_head_data),
        .i_la_addr   (r_a_sel),
        .o_la_hit    (w_la_hit),
        .o_la_data   (w_la_data),
        .i_lb_addr   (r_b_sel),
        .o_lb_hit    (w_lb_hit),
        .o_lb_data   (w_lb_data)
    );

    assign bus.wb_ready  = !w_full;
    assign bus.rd_rsp_a  = r_rsp_a;
    assign bus.rd_rsp_b  = r_rsp_b;
    assign o_rf_a_sel    = r_a_sel;
    assign o_rf_b_sel    = r_b_sel;
    assign o_rf_load_en  = !w_empty;
    assign o_rf_dest_sel = w_empty ? '0 : w_head_dest;
    assign o_rf_d_data   = w_empty ? '0 : w_head_data;

    // queued data is newer than the file, so a bypass hit wins; r0 is forced to zero last
    assign w_op_a = (ZERO_R0 != 0 && r_a_sel == '0) ? '0 : w_la_hit ? w_la_data : i_rf_a_data;
    assign w_op_b = (ZERO_R0 != 0 && r_b_sel == '0) ? '0 : w_lb_hit ? w_lb_data : i_rf_b_data;

    // read sequencer state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // read sequencer next state and handshake outputs
    always_comb begin
        w_next           = r_state;
        bus.rd_req_ready = (r_state == IDLE);
        bus.rd_rsp_valid = (r_state == RESP);
        case (r_state)
            IDLE:    if (bus.rd_req_valid) w_next = FETCH;
            FETCH:   w_next = RESP;
            RESP:    if (bus.rd_rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // selects are latched on request acceptance; operands are captured once in FETCH and held through RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sel <= '0;
            r_b_sel <= '0;
            r_rsp_a <= '0;
            r_rsp_b <= '0;
        end else begin
            if (r_state == IDLE && bus.rd_req_valid) begin
                r_a_sel <= bus.rd_req_a;
                r_b_sel <= bus.rd_req_b;
            end
            if (r_state == FETCH) begin
                r_rsp_a <= w_op_a;
                r_rsp_b <= w_op_b;
            end
        end
    end
endmodule

// File: tb/tb_regfile_port_master.sv
// tb_regfile_port_master: scoreboard bench for the register-file initiator and its writeback queue
module tb_regfile_port_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rf_a_sel, rf_b_sel, rf_dest_sel;
    logic [31:0] rf_a_data, rf_b_data, rf_d_data;
    logic        rf_load_en;
    logic [31:0] rf_mem [32];

    logic [63:0] exp_rd [$];
    logic [36:0] exp_wr [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    logic        q_push = 1'b0, q_pop = 1'b0;
    logic [4:0]  q_dest = '0, q_la = 5'd6, q_lb = 5'd9, q_hd, q_dummy_unused;
    logic [31:0] q_data = '0, q_hdata, q_lad, q_lbd;
    logic        q_full, q_empty, q_lah, q_lbh;

    always #5 clk = ~clk;

    regfile_port_master_if #(.SIZE(32)) bus ();

    regfile_port_master #(.SIZE(32), .WB_DEPTH(2), .ZERO_R0(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus.slave),
        .o_rf_a_sel    (rf_a_sel),
        .o_rf_b_sel    (rf_b_sel),
        .i_rf_a_data   (rf_a_data),
        .i_rf_b_data   (rf_b_data),
        .o_rf_load_en  (rf_load_en),
        .o_rf_dest_sel (rf_dest_sel),
        .o_rf_d_data   (rf_d_data)
    );

    regfile_wb_queue #(.SIZE(32), .DEPTH(2)) q (
        .clk (clk), .rst (rst), .i_push (q_push), .i_dest (q_dest), .i_data (q_data), .i_pop (q_pop),
        .o_full (q_full), .o_empty (q_empty), .o_head_dest (q_hd), .o_head_data (q_hdata),
        .i_la_addr (q_la), .o_la_hit (q_lah), .o_la_data (q_lad),
        .i_lb_addr (q_lb), .o_lb_hit (q_lbh), .o_lb_data (q_lbd)
    );

    // stub register file: r3=0x11, r4=0x22, others 0x1000+index
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                rf_mem[i] <= (i == 3) ? 32'h11 : (i == 4) ? 32'h22 : 32'h1000 + i;
        end else if (rf_load_en) begin
            rf_mem[rf_dest_sel] <= rf_d_data;
        end
    end
    assign rf_a_data = rf_mem[rf_a_sel];
    assign rf_b_data = rf_mem[rf_b_sel];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: compare every presented response/write against the scoreboard queues
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rd_rsp_valid && bus.rd_rsp_ready) begin
                if (exp_rd.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rd_rsp: unexpected response a=%h b=%h", bus.rd_rsp_a, bus.rd_rsp_b);
                end else begin
                    logic [63:0] e;
                    e = exp_rd.pop_front();
                    chk("rd_rsp_a", bus.rd_rsp_a, e[63:32]);
                    chk("rd_rsp_b", bus.rd_rsp_b, e[31:0]);
                end
            end
            if (rf_load_en) begin
                if (exp_wr.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rf_write: unexpected write dest=%0d data=%h", rf_dest_sel, rf_d_data);
                end else begin
                    logic [36:0] w;
                    w = exp_wr.pop_front();
                    chk("rf_dest_sel", 32'(rf_dest_sel), 32'(w[36:32]));
                    chk("rf_d_data", rf_d_data, w[31:0]);
                end
            end
        end
    end

    task automatic wb(input logic [4:0] d, input logic [31:0] v, input bit expect_write);
        bus.wb_valid = 1'b1; bus.wb_dest = d; bus.wb_data = v;
        if (expect_write) exp_wr.push_back({d, v});
        @(posedge clk); #1;
        bus.wb_valid = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [4:0] b, input logic [31:0] ea, input logic [31:0] eb);
        bus.rd_req_valid = 1'b1; bus.rd_req_a = a; bus.rd_req_b = b;
        exp_rd.push_back({ea, eb});
        @(posedge clk); #1;
        bus.rd_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!bus.rd_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_rd_req_ready", 32'(bus.rd_req_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.rd_req_valid = 0; bus.rd_req_a = 0; bus.rd_req_b = 0; bus.rd_rsp_ready = 1;
        bus.wb_valid = 0; bus.wb_dest = 0; bus.wb_data = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_rd_req_ready", 32'(bus.rd_req_ready), 32'd1);
        chk("reset_wb_ready", 32'(bus.wb_ready), 32'd1);
        chk("reset_rd_rsp_valid", 32'(bus.rd_rsp_valid), 32'd0);
        chk("reset_rd_rsp_a", bus.rd_rsp_a, 32'd0);
        chk("reset_rd_rsp_b", bus.rd_rsp_b, 32'd0);
        chk("reset_rf_load_en", 32'(rf_load_en), 32'd0);
        chk("reset_rf_dest_sel", 32'(rf_dest_sel), 32'd0);
        chk("reset_rf_d_data", rf_d_data, 32'd0);
        chk("reset_rf_a_sel", 32'(rf_a_sel), 32'd0);
        @(posedge clk); #1;

        // single writeback: one-cycle load pulse
        wb(5'd5, 32'hDEADBEEF, 1'b1);
        @(negedge clk); chk("wb5_load_en_on", 32'(rf_load_en), 32'd1);
        @(negedge clk); chk("wb5_load_en_off", 32'(rf_load_en), 32'd0);
        @(posedge clk); #1;

        // basic read with latency and ready checks
        rd(5'd3, 5'd4, 32'h11, 32'h22);
        @(negedge clk);
        chk("lat_fetch_req_ready", 32'(bus.rd_req_ready), 32'd0);
        chk("lat_fetch_rsp_valid", 32'(bus.rd_rsp_valid), 32'd0);
        @(negedge clk);
        chk("lat_resp_req_ready", 32'(bus.rd_req_ready), 32'd0);
        chk("lat_resp_rsp_valid", 32'(bus.rd_rsp_valid), 32'd1);
        @(negedge clk);
        chk("lat_idle_req_ready", 32'(bus.rd_req_ready), 32'd1);
        chk("lat_idle_rsp_valid", 32'(bus.rd_rsp_valid), 32'd0);
        @(posedge clk); #1;

        // back-to-back r7 writebacks; read issued alongside the second sees it via head bypass
        wb(5'd7, 32'hA, 1'b1);
        bus.rd_req_valid = 1'b1; bus.rd_req_a = 5'd7; bus.rd_req_b = 5'd5;
        exp_rd.push_back({32'hB, 32'hDEADBEEF});
        wb(5'd7, 32'hB, 1'b1);
        bus.rd_req_valid = 1'b0;
        wait_idle();

        // writeback accepted during FETCH is invisible to that read, visible to the next
        rd(5'd9, 5'd9, 32'h1009, 32'h1009);
        wb(5'd9, 32'h99, 1'b1);
        wait_idle();
        rd(5'd9, 5'd3, 32'h99, 32'h11);
        wait_idle();

        // sustained writebacks never drop wb_ready
        for (int i = 0; i < 3; i++) begin
            bus.wb_valid = 1'b1; bus.wb_dest = 5'(10 + i); bus.wb_data = 32'(i + 1);
            exp_wr.push_back({5'(10 + i), 32'(i + 1)});
            @(negedge clk); chk("sustain_wb_ready", 32'(bus.wb_ready), 32'd1);
            @(posedge clk); #1;
        end
        bus.wb_valid = 1'b0;
        wait_idle();
        rd(5'd10, 5'd12, 32'h1, 32'h3);
        wait_idle();

        // r0 writes are swallowed and r0 reads as zero
        wb(5'd0, 32'h55, 1'b0);
        @(negedge clk); chk("r0_no_load_en", 32'(rf_load_en), 32'd0);
        @(posedge clk); #1;
        rd(5'd0, 5'd0, 32'h0, 32'h0);
        wait_idle();

        // reset while a response is held and a write is pending
        bus.rd_rsp_ready = 1'b0;
        bus.rd_req_valid = 1'b1; bus.rd_req_a = 5'd3; bus.rd_req_b = 5'd4;
        @(posedge clk); #1 bus.rd_req_valid = 1'b0;
        @(posedge clk); #1;
        bus.wb_valid = 1'b1; bus.wb_dest = 5'd20; bus.wb_data = 32'h2020;
        @(posedge clk); #1;
        bus.wb_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("pre_rst_rsp_valid", 32'(bus.rd_rsp_valid), 32'd1);
        chk("pre_rst_load_en", 32'(rf_load_en), 32'd1);
        chk("pre_rst_dest_sel", 32'(rf_dest_sel), 32'd20);
        @(posedge clk); #1;
        rst = 1'b0; bus.rd_rsp_ready = 1'b1;
        exp_rd.delete(); exp_wr.delete();
        @(negedge clk);
        chk("post_rst_rsp_valid", 32'(bus.rd_rsp_valid), 32'd0);
        chk("post_rst_load_en", 32'(rf_load_en), 32'd0);
        chk("post_rst_req_ready", 32'(bus.rd_req_ready), 32'd1);
        chk("post_rst_wb_ready", 32'(bus.wb_ready), 32'd1);
        repeat (2) begin
            @(negedge clk); chk("post_rst_no_write", 32'(rf_load_en), 32'd0);
        end
        @(posedge clk); #1;
        rd(5'd20, 5'd4, 32'h1014, 32'h22);
        wait_idle();

        // standalone queue: fill to full, reject push while full, youngest-match lookup
        q_push = 1'b1; q_dest = 5'd6; q_data = 32'h61;
        @(posedge clk); #1 q_data = 32'h62;
        @(posedge clk); #1 q_push = 1'b0;
        @(negedge clk);
        chk("q_full", 32'(q_full), 32'd1);
        chk("q_not_empty", 32'(q_empty), 32'd0);
        chk("q_head_data", q_hdata, 32'h61);
        chk("q_la_hit", 32'(q_lah), 32'd1);
        chk("q_la_youngest", q_lad, 32'h62);
        chk("q_lb_miss", 32'(q_lbh), 32'd0);
        @(posedge clk); #1;
        q_push = 1'b1; q_pop = 1'b1; q_dest = 5'd9; q_data = 32'h99;
        @(posedge clk); #1 q_push = 1'b0; q_pop = 1'b0;
        @(negedge clk);
        chk("q_after_pop_full", 32'(q_full), 32'd0);
        chk("q_after_pop_head", q_hdata, 32'h62);
        chk("q_push_when_full_dropped", 32'(q_lbh), 32'd0);
        @(posedge clk); #1 q_pop = 1'b1;
        @(posedge clk); #1 q_pop = 1'b0;
        @(negedge clk);
        chk("q_empty", 32'(q_empty), 32'd1);
        chk("q_empty_no_hit", 32'(q_lah), 32'd0);

        repeat (3) @(negedge clk);
        chk("scoreboard_rd_drained", 32'(exp_rd.size()), 32'd0);
        chk("scoreboard_wr_drained", 32'(exp_wr.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
